// File: rtl/pipeline_stall_ctrl_pkg.sv
// pipeline_stall_ctrl_pkg: shared state encoding for the stall controller
package pipeline_stall_ctrl_pkg;
    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_FREEZE    = 2'd1,
        ST_FETCHWAIT = 2'd2
    } state_e;
endpackage

// File: rtl/pipeline_stall_ctrl_perf_sat_counter.sv
// perf_sat_counter: saturating event counter for the perf CSRs
module perf_sat_counter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc_i,
    output logic [CNT_WIDTH-1:0] count_o
);
    logic [CNT_WIDTH-1:0] count_q;
    // count up on each event, sticking at all-ones
    always_ff @(posedge clk)
        count_q <= rst ? '0 : (inc_i && !(&count_q)) ? count_q + 1'b1 : count_q;
    assign count_o = count_q;
endmodule

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: turns hazard/wait requests into pipeline enables, flushes and PC redirects
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  d_hazard_i,
    input  logic                  c_hazard_i,
    input  logic [ADDR_WIDTH-1:0] br_target_i,
    input  logic                  imem_wait_i,
    input  logic                  dmem_wait_i,
    output logic                  pc_wr_en_o,
    output logic                  pc_redirect_o,
    output logic [ADDR_WIDTH-1:0] redirect_pc_o,
    output logic                  ifid_wr_en_o,
    output logic                  ifid_flush_o,
    output logic                  idex_wr_en_o,
    output logic                  idex_flush_o,
    output logic                  exmem_wr_en_o,
    output logic [CNT_WIDTH-1:0]  stall_count_o,
    output logic [CNT_WIDTH-1:0]  flush_count_o
);
    state_e                state_q, state_d;
    logic                  pend_valid_q, pend_valid_d;
    logic [ADDR_WIDTH-1:0] pend_pc_q, pend_pc_d;
    logic                  pend_apply;
    logic                  flush_inc;
    // a held redirect only exists while frozen, so it is released on the first unfrozen cycle
    assign pend_apply = pend_valid_q && (state_q == ST_FREEZE);
    // priority resolution: memory freeze, redirect, fetch wait, data hazard, run
    always_comb begin
        state_d       = ST_RUN;
        pend_valid_d  = pend_valid_q;
        pend_pc_d     = pend_pc_q;
        pc_wr_en_o    = 1'b1;
        pc_redirect_o = 1'b0;
        redirect_pc_o = '0;
        ifid_wr_en_o  = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_wr_en_o  = 1'b1;
        idex_flush_o  = 1'b0;
        exmem_wr_en_o = 1'b1;
        flush_inc     = 1'b0;
        if (rst) begin
            pc_wr_en_o    = 1'b0;
            ifid_wr_en_o  = 1'b0;
            idex_wr_en_o  = 1'b0;
            exmem_wr_en_o = 1'b0;
            ifid_flush_o  = 1'b1;
            idex_flush_o  = 1'b1;
        end else if (dmem_wait_i) begin
            pc_wr_en_o    = 1'b0;
            ifid_wr_en_o  = 1'b0;
            idex_wr_en_o  = 1'b0;
            exmem_wr_en_o = 1'b0;
            state_d       = ST_FREEZE;
            pend_valid_d  = pend_valid_q | c_hazard_i;
            pend_pc_d     = c_hazard_i ? br_target_i : pend_pc_q;
        end else if (c_hazard_i || pend_apply) begin
            pc_redirect_o = 1'b1;
            redirect_pc_o = c_hazard_i ? br_target_i : pend_pc_q;
            ifid_flush_o  = 1'b1;
            pend_valid_d  = 1'b0;
            flush_inc     = 1'b1;
        end else if (imem_wait_i) begin
            pc_wr_en_o    = 1'b0;
            ifid_wr_en_o  = 1'b0;
            idex_flush_o  = 1'b1;
            state_d       = ST_FETCHWAIT;
        end else if (d_hazard_i) begin
            pc_wr_en_o    = 1'b0;
            ifid_wr_en_o  = 1'b0;
            idex_flush_o  = 1'b1;
        end
    end
    // state and pending-redirect registers; reset drops any held redirect
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            pend_valid_q <= 1'b0;
            pend_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pend_valid_q <= pend_valid_d;
            pend_pc_q    <= pend_pc_d;
        end
    end
    perf_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (!pc_wr_en_o && !rst),
        .count_o (stall_count_o)
    );
    perf_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (flush_inc),
        .count_o (flush_count_o)
    );
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl: directed and randomised checks of the stall controller against a behavioural model
module tb_pipeline_stall_ctrl;
    localparam int CW = 5;
    localparam int MAXC = (1 << CW) - 1;

    logic clk = 0, rst = 1, dh = 0, ch = 0, im = 0, dm = 0;
    logic [31:0] br = 0;
    logic pc_wr, redir, ifid_wr, ifid_fl, idex_wr, idex_fl, exmem_wr;
    logic [31:0] rpc;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int checks = 0, errors = 0;

    pipeline_stall_ctrl #(.ADDR_WIDTH(32), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .d_hazard_i(dh), .c_hazard_i(ch), .br_target_i(br),
        .imem_wait_i(im), .dmem_wait_i(dm), .pc_wr_en_o(pc_wr), .pc_redirect_o(redir),
        .redirect_pc_o(rpc), .ifid_wr_en_o(ifid_wr), .ifid_flush_o(ifid_fl),
        .idex_wr_en_o(idex_wr), .idex_flush_o(idex_fl), .exmem_wr_en_o(exmem_wr),
        .stall_count_o(stall_cnt), .flush_count_o(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        pc_wr;
        logic        redir;
        logic [31:0] rpc;
        logic        ifid_wr;
        logic        ifid_fl;
        logic        idex_wr;
        logic        idex_fl;
        logic        exmem_wr;
    } exp_t;

    // model state: held redirect and event tallies
    bit          m_pend = 0;
    logic [31:0] m_pend_pc = 0;
    int          m_stall = 0, m_flush = 0;
    bit          armed = 0;

    function automatic exp_t model_out(logic r, logic d, logic c, logic [31:0] b, logic i, logic m,
                                       bit pv, logic [31:0] pp);
        exp_t e;
        bit take, hold_front;
        take       = !m && (c || pv);
        hold_front = !m && !take && (i || d);
        if (r) begin
            e = '{1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        end else begin
            e.pc_wr    = !m && !hold_front;
            e.redir    = take;
            e.rpc      = take ? (c ? b : pp) : 32'd0;
            e.ifid_wr  = !m && !hold_front;
            e.ifid_fl  = take;
            e.idex_wr  = !m;
            e.idex_fl  = hold_front;
            e.exmem_wr = !m;
        end
        return e;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // model update at each active edge
    always @(posedge clk) begin
        exp_t e;
        e = model_out(rst, dh, ch, br, im, dm, m_pend, m_pend_pc);
        if (rst) begin
            m_pend = 0; m_pend_pc = 0; m_stall = 0; m_flush = 0; armed = 1;
        end else begin
            if (dm && ch) begin m_pend = 1; m_pend_pc = br; end
            if (e.redir) m_pend = 0;
            if (!e.pc_wr && m_stall < MAXC) m_stall++;
            if (e.redir && m_flush < MAXC) m_flush++;
        end
    end

    // every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        exp_t e;
        if (armed) begin
            e = model_out(rst, dh, ch, br, im, dm, m_pend, m_pend_pc);
            chk("pc_wr", {31'd0, pc_wr}, {31'd0, e.pc_wr});
            chk("redirect", {31'd0, redir}, {31'd0, e.redir});
            if (e.redir) chk("redirect_pc", rpc, e.rpc);
            chk("ifid_wr", {31'd0, ifid_wr}, {31'd0, e.ifid_wr});
            chk("ifid_flush", {31'd0, ifid_fl}, {31'd0, e.ifid_fl});
            chk("idex_wr", {31'd0, idex_wr}, {31'd0, e.idex_wr});
            chk("idex_flush", {31'd0, idex_fl}, {31'd0, e.idex_fl});
            chk("exmem_wr", {31'd0, exmem_wr}, {31'd0, e.exmem_wr});
            chk("stall_count", 32'(stall_cnt), 32'(m_stall));
            chk("flush_count", 32'(flush_cnt), 32'(m_flush));
        end
    end

    task automatic drive(logic r, logic d, logic c, logic [31:0] b, logic i, logic m);
        rst = r; dh = d; ch = c; br = b; im = i; dm = m;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset two cycles
        drive(1, 0, 0, 0, 0, 0);
        chk("rst_pc_wr", {31'd0, pc_wr}, 0);
        chk("rst_ifid_flush", {31'd0, ifid_fl}, 1);
        chk("rst_idex_flush", {31'd0, idex_fl}, 1);
        tick(); tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("idle_pc_wr", {31'd0, pc_wr}, 1);
        chk("idle_ifid_flush", {31'd0, ifid_fl}, 0);
        chk("idle_stall_cnt", 32'(stall_cnt), 0);
        chk("idle_flush_cnt", 32'(flush_cnt), 0);
        tick();
        // data hazard
        drive(0, 1, 0, 0, 0, 0);
        chk("dh_pc_wr", {31'd0, pc_wr}, 0);
        chk("dh_ifid_wr", {31'd0, ifid_wr}, 0);
        chk("dh_idex_flush", {31'd0, idex_fl}, 1);
        tick();
        chk("dh_stall_cnt", 32'(stall_cnt), 1);
        // taken branch
        drive(0, 0, 1, 32'h40, 0, 0);
        chk("br_redirect", {31'd0, redir}, 1);
        chk("br_pc", rpc, 32'h40);
        chk("br_ifid_flush", {31'd0, ifid_fl}, 1);
        tick();
        chk("br_flush_cnt", 32'(flush_cnt), 1);
        // freeze three cycles with a branch in the first
        drive(0, 0, 1, 32'h80, 0, 1);
        chk("frz_pc_wr", {31'd0, pc_wr}, 0);
        chk("frz_exmem_wr", {31'd0, exmem_wr}, 0);
        chk("frz_ifid_flush", {31'd0, ifid_fl}, 0);
        tick();
        drive(0, 0, 0, 0, 0, 1); tick();
        drive(0, 0, 0, 0, 0, 1); tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("rel_redirect", {31'd0, redir}, 1);
        chk("rel_pc", rpc, 32'h80);
        chk("frz_stall_cnt", 32'(stall_cnt), 4);
        chk("frz_flush_cnt", 32'(flush_cnt), 1);
        tick();
        chk("rel_flush_cnt", 32'(flush_cnt), 2);
        // two branches during freeze: latest wins, applied once
        drive(0, 0, 1, 32'h80, 0, 1); tick();
        drive(0, 0, 1, 32'hC0, 0, 1); tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("latest_pc", rpc, 32'hC0);
        tick();
        chk("latest_flush_cnt", 32'(flush_cnt), 3);
        drive(0, 0, 0, 0, 0, 0);
        chk("once_redirect", {31'd0, redir}, 0);
        tick();
        // fetch wait, then branch during fetch wait
        drive(0, 0, 0, 0, 1, 0);
        chk("fw_pc_wr", {31'd0, pc_wr}, 0);
        chk("fw_idex_flush", {31'd0, idex_fl}, 1);
        chk("fw_exmem_wr", {31'd0, exmem_wr}, 1);
        tick();
        drive(0, 0, 1, 32'h100, 1, 0);
        chk("fw_br_redirect", {31'd0, redir}, 1);
        chk("fw_br_pc_wr", {31'd0, pc_wr}, 1);
        tick();
        // illegal cHazard+dHazard: branch wins
        drive(0, 1, 1, 32'h140, 0, 0);
        chk("cd_redirect", {31'd0, redir}, 1);
        chk("cd_idex_flush", {31'd0, idex_fl}, 0);
        tick();
        // reset mid-freeze drops held redirect
        drive(0, 0, 1, 32'h200, 0, 1); tick();
        drive(1, 0, 0, 0, 0, 1); tick();
        chk("rst_stall_cnt", 32'(stall_cnt), 0);
        chk("rst_flush_cnt", 32'(flush_cnt), 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("rst_no_redirect", {31'd0, redir}, 0);
        tick();
        // saturation
        for (int k = 0; k < 40; k++) begin drive(0, 1, 0, 0, 0, 0); tick(); end
        chk("sat_stall", 32'(stall_cnt), MAXC);
        for (int k = 0; k < 40; k++) begin drive(0, 0, 1, 32'(k * 4), 0, 0); tick(); end
        chk("sat_flush", 32'(flush_cnt), MAXC);
        chk("sat_stall_hold", 32'(stall_cnt), MAXC);
        // mixed traffic, including a reset to revisit counting from zero
        for (int k = 0; k < 300; k++) begin
            drive(k == 150, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                  $urandom & 32'hFFFC, $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0);
            tick();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
